// File: rtl/xc_lane_tx.sv
// xc_lane_tx
// ----------
// Transmit side of the X-lane link. Accepts one parallel frame per input
// handshake (X two-bit lane symbols plus an X-bit lane-enable mask) and
// serializes the enabled lanes, lowest index first, onto a 2-bit link with
// SOF/EOF framing. Frames with an all-zero mask are consumed and counted as
// drops without any link activity.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_valid/in_ready transfer a frame into the block;
// lnk_vld/lnk_rdy transfer one symbol to the link sink. While lnk_vld is high
// and lnk_rdy is low, lnk_dat/lnk_sof/lnk_eof hold stable. All outputs come
// from registered state only (no combinational input-to-output path).
//
// Ports
//   clk, rstb            clock, asynchronous active-low reset
//   in_valid, in_ready   frame input handshake
//   xc[X-1:0][1:0]       lane symbols, lane i = xc[i]
//   xa[X-1:0]            lane-enable mask
//   lnk_vld, lnk_rdy     link symbol handshake
//   lnk_dat[1:0]         link symbol
//   lnk_sof, lnk_eof     first / last symbol of a frame
//   busy                 FSM state (1 = SEND, a frame is held)
//   yb                   frames completely sent, wraps
//   drop_cnt             zero-mask frames accepted, wraps

module xc_lane_tx #(
    parameter int X = 4,
    parameter int Y = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [X-1:0][1:0] xc,
    input  logic [X-1:0]      xa,
    output logic              lnk_vld,
    input  logic              lnk_rdy,
    output logic [1:0]        lnk_dat,
    output logic              lnk_sof,
    output logic              lnk_eof,
    output logic              busy,
    output logic [X*Y-1:0]    yb,
    output logic [X*Y-1:0]    drop_cnt
);

    localparam int CW = X * Y;
    localparam int LW = (X > 1) ? $clog2(X) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [X-1:0][1:0] xc_q;
    // Lanes still to be sent in this frame, current lane included.
    logic [X-1:0]      rem_q;
    logic              sof_q;

    logic [LW-1:0]     cur_idx;
    logic              cur_found;
    logic [X-1:0]      rem_after;
    logic              last_lane;
    logic              accept;
    logic              xfer;

    // Current lane = lowest set bit of the remaining mask.
    always_comb begin
        cur_idx   = '0;
        cur_found = 1'b0;
        for (int i = 0; i < X; i++) begin
            if (!cur_found && rem_q[i]) begin
                cur_idx   = LW'(i);
                cur_found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves the lanes after the current one;
    // disabled lanes are thereby skipped without spending a cycle.
    assign rem_after = rem_q & (rem_q - X'(1));
    assign last_lane = (rem_after == '0);

    assign accept = in_valid && (state_q == ST_IDLE);
    assign xfer   = lnk_rdy && (state_q == ST_SEND);

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        lnk_vld  = 1'b0;
        lnk_dat  = 2'b00;
        lnk_sof  = 1'b0;
        lnk_eof  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept && (xa != '0)) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                lnk_vld = 1'b1;
                busy    = 1'b1;
                lnk_dat = xc_q[cur_idx];
                lnk_sof = sof_q;
                lnk_eof = last_lane;
                if (xfer && last_lane) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Held frame: captured only on accept, consumed lane by lane on transfer.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            xc_q  <= '0;
            rem_q <= '0;
            sof_q <= 1'b0;
        end else if (accept) begin
            xc_q  <= xc;
            rem_q <= xa;
            sof_q <= 1'b1;
        end else if (xfer) begin
            rem_q <= rem_after;
            sof_q <= 1'b0;
        end
    end

    // Wrap-around frame counters
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            yb       <= '0;
            drop_cnt <= '0;
        end else begin
            if (xfer && last_lane) begin
                yb <= yb + CW'(1);
            end
            if (accept && (xa == '0)) begin
                drop_cnt <= drop_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_xc_lane_tx.sv
// Bench for xc_lane_tx (X=4, Y=1). A reference model turns every accepted
// frame into the list of link symbols it must produce ({sof, eof, dat}) and
// tracks the two counters; a negedge monitor compares the link, handshake and
// counter outputs against that model every cycle.

module tb_xc_lane_tx;

    localparam int X    = 4;
    localparam int Y    = 1;
    localparam int CMOD = 1 << (X * Y);

    logic              clk;
    logic              rstb;
    logic              in_valid;
    logic              in_ready;
    logic [X-1:0][1:0] xc;
    logic [X-1:0]      xa;
    logic              lnk_vld;
    logic              lnk_rdy;
    logic [1:0]        lnk_dat;
    logic              lnk_sof;
    logic              lnk_eof;
    logic              busy;
    logic [X*Y-1:0]    yb;
    logic [X*Y-1:0]    drop_cnt;

    xc_lane_tx #(.X(X), .Y(Y)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xc       (xc),
        .xa       (xa),
        .lnk_vld  (lnk_vld),
        .lnk_rdy  (lnk_rdy),
        .lnk_dat  (lnk_dat),
        .lnk_sof  (lnk_sof),
        .lnk_eof  (lnk_eof),
        .busy     (busy),
        .yb       (yb),
        .drop_cnt (drop_cnt)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];   // {sof, eof, dat} per expected link symbol
    int         m_yb;
    int         m_drop;
    int         total;
    int         bad;
    logic       rdy_rand;
    time        last_acc_time;
    time        last_eof_time;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the enabled lanes in ascending order, SOF on the first,
    // EOF on the highest enabled lane.
    task automatic model_accept(input logic [X-1:0][1:0] c, input logic [X-1:0] a);
        int   hi;
        logic first;
        hi    = -1;
        first = 1'b1;
        for (int i = 0; i < X; i++) if (a[i]) hi = i;
        if (hi < 0) begin
            m_drop = (m_drop + 1) % CMOD;
        end else begin
            for (int i = 0; i < X; i++) begin
                if (a[i]) begin
                    exp_q.push_back({first, 1'(i == hi), c[i]});
                    first = 1'b0;
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
        chk("lnk_vld", 32'(lnk_vld), 32'(exp_q.size() != 0));
        chk("yb", 32'(yb), 32'(m_yb));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (exp_q.size() != 0) begin
            chk("symbol", 32'({lnk_sof, lnk_eof, lnk_dat}), 32'(exp_q[0]));
            if (lnk_rdy) begin
                if (exp_q[0][2]) begin
                    m_yb          = (m_yb + 1) % CMOD;
                    last_eof_time = $time + 5;
                end
                void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_symbol", 32'({lnk_sof, lnk_eof, lnk_dat}), 32'(0));
        end
    end

    // ---------------- link-ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) lnk_rdy = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [X-1:0][1:0] c, input logic [X-1:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 32'(1));
        in_valid = 1'b1;
        xc       = c;
        xa       = a;
        @(posedge clk);
        last_acc_time = $time;
        model_accept(c, a);
        #1;
        in_valid = 1'b0;
        xc       = X*2'($urandom);
        xa       = X'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 500), 32'(1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [X-1:0][1:0] c;
        logic [X-1:0]      a;

        total    = 0;
        bad      = 0;
        m_yb     = 0;
        m_drop   = 0;
        rdy_rand = 1'b0;
        rstb     = 1'b0;
        in_valid = 1'b0;
        xc       = '0;
        xa       = '0;
        lnk_rdy  = 1'b0;
        last_acc_time = 0;
        last_eof_time = 0;

        #1;
        chk("reset_outs", 32'({in_ready, lnk_vld, lnk_sof, lnk_eof, lnk_dat, busy}), 32'(7'b1000000));
        repeat (2) @(posedge clk);
        #1;
        rstb    = 1'b1;
        lnk_rdy = 1'b1;

        // all four lanes, symbols 0,1,2,3 on consecutive cycles
        send_frame({2'd3, 2'd2, 2'd1, 2'd0}, 4'b1111);
        wait_idle();
        chk("full_frame_cycles", 32'(last_eof_time - last_acc_time), 32'(40));
        chk("yb_after_first", 32'(yb), 32'(1));

        // sparse mask: lanes 1 and 3 only
        send_frame({2'd2, 2'd3, 2'd1, 2'd0}, 4'b1010);
        wait_idle();
        chk("sparse_frame_cycles", 32'(last_eof_time - last_acc_time), 32'(20));

        // single lane: SOF and EOF together
        send_frame({2'd1, 2'd3, 2'd0, 2'd2}, 4'b0100);
        wait_idle();
        chk("single_frame_cycles", 32'(last_eof_time - last_acc_time), 32'(10));

        // three zero-mask frames back to back
        for (int i = 0; i < 3; i++) send_frame(X*2'($urandom), 4'b0000);
        @(negedge clk);
        chk("drop_three", 32'(drop_cnt), 32'(3));
        chk("yb_unchanged", 32'(yb), 32'(3));

        // stall 5 cycles after the first symbol, inputs wiggling meanwhile
        send_frame({2'd2, 2'd0, 2'd3, 2'd1}, 4'b1111);
        @(posedge clk);
        #1;
        lnk_rdy  = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            xc = X*2'($urandom);
            xa = X'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        lnk_rdy  = 1'b1;
        wait_idle();
        chk("stall_frame_cycles", 32'(last_eof_time - last_acc_time), 32'(90));
        chk("yb_after_stall", 32'(yb), 32'(4));

        // wrap the sent counter: 12 more frames takes it from 4 to 0
        for (int i = 0; i < 12; i++) begin
            c = X*2'($urandom);
            send_frame(c, 4'b0001 << $urandom_range(0, 3));
        end
        wait_idle();
        chk("yb_wrap", 32'(yb), 32'(0));

        // random frames with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            c = X*2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? '0 : X'($urandom);
            send_frame(c, a);
        end
        rdy_rand = 1'b0;
        lnk_rdy  = 1'b1;
        wait_idle();

        // reset in the middle of the second symbol
        send_frame({2'd3, 2'd1, 2'd2, 2'd3}, 4'b1111);
        @(posedge clk);
        #2;
        rstb = 1'b0;
        exp_q.delete();
        m_yb   = 0;
        m_drop = 0;
        #1;
        chk("midreset_outs", 32'({in_ready, lnk_vld, lnk_sof, lnk_eof, lnk_dat, busy}), 32'(7'b1000000));
        chk("midreset_yb", 32'(yb), 32'(0));
        chk("midreset_drop", 32'(drop_cnt), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;

        send_frame({2'd1, 2'd2, 2'd3, 2'd0}, 4'b0110);
        wait_idle();
        chk("post_reset_yb", 32'(yb), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xc_lane_tx.md
# xc_lane_tx

Transmit-side counterpart of the X-lane `xc`/`xa` consumer. The block accepts one parallel frame per handshake: X two-bit lane symbols plus an X-bit lane-enable mask. It serializes the enabled lanes, lowest index first, onto a 2-bit link with SOF/EOF framing and downstream backpressure. It sits between the lane producer and the narrow link feeding the receiver, and keeps wrap-around counters of sent and dropped frames.

## Interface
Parameters
- `X`, default 4: number of lanes per frame (≥1).
- `Y`, default 1: counter width multiplier; both counters are `X*Y` bits.

Ports
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rstb`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  frame offered.
- `in_ready`  out  1  block can accept a frame.
- `xc`  in  [X-1:0][1:0]  lane symbols; lane i is `xc[i]`.
- `xa`  in  [X-1:0]  lane-enable mask; lane i is sent only when `xa[i]`=1.
- `lnk_vld`  out  1  link symbol valid.
- `lnk_rdy`  in  1  link sink accepts the symbol.
- `lnk_dat`  out  [1:0]  link symbol.
- `lnk_sof`  out  1  first symbol of a frame.
- `lnk_eof`  out  1  last symbol of a frame; may coincide with `lnk_sof`.
- `busy`  out  1  a frame is held internally.
- `yb`  out  [X*Y-1:0]  frames completely sent; wraps modulo 2^(X*Y).
- `drop_cnt`  out  [X*Y-1:0]  zero-mask frames accepted; wraps.

## Operation
- States:
  - IDLE: `in_ready`=1, `lnk_vld`=0.
  - SEND: `in_ready`=0, `lnk_vld`=1.
- Accept: `in_valid && in_ready` on a clock edge.
  - Registers `xc` and `xa`.
  - If the mask is nonzero, sets the current lane to the lowest set mask bit and moves to SEND.
  - If the mask is all-zero, the frame is consumed and discarded: `drop_cnt`+1, state stays IDLE, no link activity.
- SEND outputs:
  - `lnk_dat` = held symbol of the current lane.
  - `lnk_sof`=1 only for the first enabled lane of the frame.
  - `lnk_eof`=1 when no higher-index enabled lane remains.
- Link transfer: `lnk_vld && lnk_rdy` on a clock edge.
  - If not EOF: the current lane advances to the next higher set mask bit. Disabled lanes are skipped in zero cycles; the priority search runs over the remaining mask.
  - If EOF: `yb`+1 and the state returns to IDLE.
- Stall: while `lnk_vld`=1 and `lnk_rdy`=0, `lnk_dat`, `lnk_sof`, `lnk_eof` and the current lane hold stable.
- Input isolation: `xc`/`xa` are ignored outside the accept cycle. Held data does not change mid-frame.
- `busy` = (state == SEND).
- Reset, from any state including mid-frame:
  - Returns immediately to IDLE; the held frame is abandoned with no EOF emitted.
  - Output values during reset: `in_ready`=1, `lnk_vld`=0, `lnk_sof`=0, `lnk_eof`=0, `lnk_dat`=0, `busy`=0, `yb`=0, `drop_cnt`=0.

## Timing
- Latency: frame accepted at edge N → first symbol valid in the cycle after edge N.
- Throughput: k enabled lanes with `lnk_rdy` held high take k cycles in SEND. `in_ready` rises in the cycle after the EOF transfer, so there is 1 idle cycle per frame. Sustained rate is k symbols per k+1 cycles.
- Zero-mask frames can be accepted back-to-back, one per cycle.
- Register update timing:
  - `yb` updates on the EOF-transfer edge.
  - `drop_cnt` updates on the accept edge.
- Counters wrap from all-ones to 0 with no saturation and no flag.
- All outputs are registered or decoded from registered state only. There is no combinational path from `lnk_rdy` or `in_valid` to any output.

## Test plan
- X=4, frame `xc`={3,2,1,0} (lane3..lane0), `xa`=4'b1111, `lnk_rdy`=1 → `lnk_dat` 0,1,2,3 on 4 consecutive cycles; SOF on the first symbol, EOF on the fourth; `in_ready` high 1 cycle later; `yb`=1.
- `xa`=4'b1010, `xc`={2,3,1,0} → exactly two symbols, 1 then 2; SOF on the first, EOF on the second; lanes 0 and 2 never appear.
- `xa`=4'b0100 → single symbol with SOF=EOF=1.
- `xa`=4'b0000 on 3 consecutive cycles → `in_ready` stays 1, `lnk_vld` stays 0, `drop_cnt`=3, `yb` unchanged.
- `lnk_rdy` held low 5 cycles after the first symbol of a 4-lane frame → symbol, SOF and EOF held stable; the frame completes 5 cycles later than the unstalled case; inputs changing meanwhile are ignored.
- Reset pulse (`rstb`=0) during the second symbol → same cycle: `lnk_vld`=0, `in_ready`=1, counters 0. After release, a new frame transmits normally starting with SOF.
- Y=1, X=2: send 4 frames → `yb` counts 1, 2, 3, then wraps to 0.
